// File: rtl/rotate_apb_regfile.sv
// APB slave register file for the rotate engine: config, start pulse, busy/done/err status, IRQ.
// Build with ROTATE_REGFILE_ID_EN defined to add the read-only ID register at 0x14.
module rotate_apb_regfile #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DIM_W       = 12,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'h524F_5401
) (
   input  logic              I_PCLK,
   input  logic              I_PRESET_N,
   input  logic              I_PSEL,
   input  logic              I_PENABLE,
   input  logic              I_PWRITE,
   input  logic [ADDR_W-1:0] I_PADDR,
   input  logic [DATA_W-1:0] I_PWDATA,
   output logic [DATA_W-1:0] O_PRDATA,
   output logic              O_PREADY,
   output logic              O_PSLVERR,
   input  logic              I_DONE,
   output logic              O_START,
   output logic [1:0]        O_MODE,
   output logic [DATA_W-1:0] O_SRC_ADDR,
   output logic [DATA_W-1:0] O_DST_ADDR,
   output logic [DIM_W-1:0]  O_IMG_W,
   output logic [DIM_W-1:0]  O_IMG_H,
   output logic              O_IRQ
);

   localparam logic [2:0]        WS       = 3'(WAIT_STATES);
   localparam logic [ADDR_W-1:0] W_CTRL   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] W_STATUS = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] W_SRC    = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] W_DST    = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] W_SIZE   = ADDR_W'(4);
`ifdef ROTATE_REGFILE_ID_EN
   localparam logic [ADDR_W-1:0] W_ID     = ADDR_W'(5);
`endif

   // The bus setup phase is the IDLE cycle with PSEL=1/PENABLE=0, so a zero-wait access takes 2 cycles.
   typedef enum logic {IDLE, ACCESS} state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              ready;
   logic [ADDR_W-1:0] word;

   logic [1:0]        mode_q, mode_d;
   logic              ie_q, ie_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              start_q, start_d, irq_q;
   logic [DATA_W-1:0] src_q, src_d, dst_q, dst_d, rdata;
   logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
   logic              slverr, done_ev, busy_eff;

   assign word = I_PADDR >> 2;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready   = 1'b0;
      case (state_q)
         IDLE: if (I_PSEL && !I_PENABLE) begin
            state_d = ACCESS;
            cnt_d   = WS;
         end
         ACCESS: begin
            if (!I_PSEL) begin
               state_d = IDLE;
            end else if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               ready   = !I_PRESET_N;
               state_d = IDLE;
            end
         end
      endcase
   end

   // An engine completion is applied before any same-cycle bus write sees BUSY.
   assign done_ev  = I_DONE && busy_q;
   assign busy_eff = busy_q && !done_ev;

   always_comb begin
      mode_d  = mode_q;
      ie_d    = ie_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      src_d   = src_q;
      dst_d   = dst_q;
      w_d     = w_q;
      h_d     = h_q;
      start_d = 1'b0;
      slverr  = 1'b0;
      rdata   = '0;
      if (done_ev) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
      if (ready) begin
         case (word)
            W_CTRL: begin
               if (!I_PWRITE) begin
                  rdata[3:0] = {ie_q, mode_q, 1'b0};
               end else if (busy_eff) begin
                  slverr = 1'b1;
                  if (I_PWDATA[0]) err_d = 1'b1;
               end else begin
                  mode_d = I_PWDATA[2:1];
                  ie_d   = I_PWDATA[3];
                  if (I_PWDATA[0]) begin
                     start_d = 1'b1;
                     busy_d  = 1'b1;
                     done_d  = 1'b0;
                  end
               end
            end
            W_STATUS: begin
               if (!I_PWRITE) begin
                  rdata[2:0] = {err_q, done_q, busy_q};
               end else begin
                  if (I_PWDATA[1]) done_d = done_ev;
                  if (I_PWDATA[2]) err_d = 1'b0;
               end
            end
            W_SRC: begin
               if (!I_PWRITE)     rdata  = src_q;
               else if (busy_eff) slverr = 1'b1;
               else               src_d  = I_PWDATA;
            end
            W_DST: begin
               if (!I_PWRITE)     rdata  = dst_q;
               else if (busy_eff) slverr = 1'b1;
               else               dst_d  = I_PWDATA;
            end
            W_SIZE: begin
               if (!I_PWRITE) begin
                  rdata[DIM_W-1:0]  = w_q;
                  rdata[16 +: DIM_W] = h_q;
               end else if (busy_eff) begin
                  slverr = 1'b1;
               end else begin
                  w_d = I_PWDATA[DIM_W-1:0];
                  h_d = I_PWDATA[16 +: DIM_W];
               end
            end
`ifdef ROTATE_REGFILE_ID_EN
            W_ID: begin
               if (!I_PWRITE) rdata  = DATA_W'(ID_VALUE);
               else           slverr = 1'b1;
            end
`endif
            default: slverr = 1'b1;
         endcase
      end
   end

`ifndef ROTATE_REGFILE_ID_EN
   // ID_VALUE has no effect in this build.
   if (ID_VALUE == 32'h0) begin : g_no_id
   end
`endif

   always_ff @(posedge I_PCLK) begin
      if (I_PRESET_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= '0;
         ie_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         irq_q   <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         w_q     <= '0;
         h_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         ie_q    <= ie_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         start_q <= start_d;
         irq_q   <= (done_q | err_q) & ie_q;
         src_q   <= src_d;
         dst_q   <= dst_d;
         w_q     <= w_d;
         h_q     <= h_d;
      end
   end

   assign O_PREADY   = ready;
   assign O_PRDATA   = rdata;
   assign O_PSLVERR  = slverr;
   assign O_START    = start_q;
   assign O_MODE     = mode_q;
   assign O_SRC_ADDR = src_q;
   assign O_DST_ADDR = dst_q;
   assign O_IMG_W    = w_q;
   assign O_IMG_H    = h_q;
   assign O_IRQ      = irq_q;

endmodule

// File: tb/tb_rotate_apb_regfile.sv
// Directed bench for rotate_apb_regfile: zero-wait instance plus a WAIT_STATES=3 instance.
module tb_rotate_apb_regfile;
   logic        clk = 1'b0, rst = 1'b1;
   logic        psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic        done0 = 1'b0, done1 = 1'b0;

   logic [31:0] prdata0, prdata1, src0, src1, dst0, dst1;
   logic        pready0, pready1, pslverr0, pslverr1, start0, start1, irq0, irq1;
   logic [1:0]  mode0, mode1;
   logic [11:0] w0, w1, h0, h1;

   int ntests = 0, nfail = 0, nstart0 = 0;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
      bit          rd;
      int          waits;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) if (start0 === 1'b1) nstart0 <= nstart0 + 1;

   rotate_apb_regfile #(.WAIT_STATES(0)) u_dut (
      .I_PCLK(clk), .I_PRESET_N(rst), .I_PSEL(psel0), .I_PENABLE(penable), .I_PWRITE(pwrite),
      .I_PADDR(paddr), .I_PWDATA(pwdata), .O_PRDATA(prdata0), .O_PREADY(pready0),
      .O_PSLVERR(pslverr0), .I_DONE(done0), .O_START(start0), .O_MODE(mode0),
      .O_SRC_ADDR(src0), .O_DST_ADDR(dst0), .O_IMG_W(w0), .O_IMG_H(h0), .O_IRQ(irq0));

   rotate_apb_regfile #(.WAIT_STATES(3)) u_dw (
      .I_PCLK(clk), .I_PRESET_N(rst), .I_PSEL(psel1), .I_PENABLE(penable), .I_PWRITE(pwrite),
      .I_PADDR(paddr), .I_PWDATA(pwdata), .O_PRDATA(prdata1), .O_PREADY(pready1),
      .O_PSLVERR(pslverr1), .I_DONE(done1), .O_START(start1), .O_MODE(mode1),
      .O_SRC_ADDR(src1), .O_DST_ADDR(dst1), .O_IMG_W(w1), .O_IMG_H(h1), .O_IRQ(irq1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // d selects the instance; dn raises I_DONE during the access cycle.
   task automatic apb(input bit d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input string tag, input bit dn = 1'b0);
      exp_t e;
      int   n;
      bit   got;
      e.tag = tag; e.data = er; e.err = ee; e.rd = !wr; e.waits = d ? 3 : 0;
      sbq.push_back(e);
      @(posedge clk); #1;
      if (d) psel1 = 1'b1; else psel0 = 1'b1;
      penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      if (dn) done0 = 1'b1;
      n = 0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((d ? pready1 : pready0) === 1'b1) got = 1'b1; else n++;
      end
      e = sbq.pop_front();
      ntests++;
      assert (got) else begin
         nfail++;
         $error("FAIL %s_timeout: observed no PREADY expected PREADY within 20 cycles", e.tag);
      end
      if (got) begin
         if (e.rd) chk({e.tag, "_rdata"}, d ? prdata1 : prdata0, e.data);
         chk({e.tag, "_slverr"}, 32'(d ? pslverr1 : pslverr0), 32'(e.err));
         chk({e.tag, "_waits"}, 32'(n), 32'(e.waits));
      end
      @(posedge clk); #1;
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; done0 = 1'b0;
   endtask

   task automatic pulse_done();
      @(posedge clk); #1 done0 = 1'b1;
      @(posedge clk); #1 done0 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a bus request pending: no PREADY may appear.
      @(posedge clk); #1 psel0 = 1'b1;
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk);
      chk("rst_pready", 32'(pready0), 32'd0);
      @(posedge clk); #1 psel0 = 1'b0; penable = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_irq", 32'(irq0), 32'd0);
      chk("rst_start", 32'(start0), 32'd0);
      chk("rst_mode", 32'(mode0), 32'd0);
      chk("rst_src", src0, 32'd0);
      chk("rst_prdata_idle", prdata0, 32'd0);

      apb(0, 0, 8'h00, 0, 32'h0, 1'b0, "rd_ctrl0");
      apb(0, 0, 8'h04, 0, 32'h0, 1'b0, "rd_status0");
      apb(0, 0, 8'h08, 0, 32'h0, 1'b0, "rd_src0");
      apb(0, 0, 8'h0C, 0, 32'h0, 1'b0, "rd_dst0");
      apb(0, 0, 8'h10, 0, 32'h0, 1'b0, "rd_size0");

      apb(0, 1, 8'h08, 32'h1000_0000, 0, 1'b0, "wr_src");
      apb(0, 1, 8'h0C, 32'h2000_0000, 0, 1'b0, "wr_dst");
      apb(0, 1, 8'h10, 32'h00F0_0140, 0, 1'b0, "wr_size");
      apb(0, 1, 8'h00, 32'h0000_000B, 0, 1'b0, "wr_ctrl_start");
      chk("out_mode", 32'(mode0), 32'd1);
      chk("out_w", 32'(w0), 32'd320);
      chk("out_h", 32'(h0), 32'd240);
      chk("out_src", src0, 32'h1000_0000);
      chk("out_dst", dst0, 32'h2000_0000);
      apb(0, 0, 8'h04, 0, 32'h1, 1'b0, "rd_status_busy");
      apb(0, 0, 8'h00, 0, 32'h0A, 1'b0, "rd_ctrl");
      apb(0, 0, 8'h10, 0, 32'h00F0_0140, 1'b0, "rd_size");
      chk("start_count1", 32'(nstart0), 32'd1);

      apb(0, 1, 8'h00, 32'h1, 0, 1'b1, "wr_ctrl_busy");
      @(negedge clk) chk("irq_lag0", 32'(irq0), 32'd0);
      @(negedge clk) chk("irq_set", 32'(irq0), 32'd1);
      apb(0, 1, 8'h08, 32'h5, 0, 1'b1, "wr_src_locked");
      apb(0, 0, 8'h08, 0, 32'h1000_0000, 1'b0, "rd_src_kept");
      apb(0, 0, 8'h04, 0, 32'h5, 1'b0, "rd_status_err");
      chk("mode_kept", 32'(mode0), 32'd1);
      chk("start_count_busy", 32'(nstart0), 32'd1);

      pulse_done();
      apb(0, 0, 8'h04, 0, 32'h6, 1'b0, "rd_status_done");
      apb(0, 1, 8'h04, 32'h6, 0, 1'b0, "w1c_status");
      @(negedge clk) chk("irq_hold", 32'(irq0), 32'd1);
      @(negedge clk) chk("irq_clear", 32'(irq0), 32'd0);
      apb(0, 0, 8'h04, 0, 32'h0, 1'b0, "rd_status_clr");

      apb(0, 1, 8'h00, 32'hB, 0, 1'b0, "start2");
      pulse_done();
      apb(0, 0, 8'h04, 0, 32'h2, 1'b0, "rd_status_done2");
      apb(0, 1, 8'h00, 32'hB, 0, 1'b0, "start3");
      apb(0, 0, 8'h04, 0, 32'h1, 1'b0, "rd_status_start3");
      apb(0, 1, 8'h04, 32'h2, 0, 1'b0, "w1c_vs_done", 1'b1);
      apb(0, 0, 8'h04, 0, 32'h2, 1'b0, "rd_done_wins");
      chk("start_count3", 32'(nstart0), 32'd3);

      apb(0, 1, 8'h00, 32'hB, 0, 1'b0, "start4");
      apb(0, 1, 8'h00, 32'hB, 0, 1'b0, "start_with_done", 1'b1);
      apb(0, 0, 8'h04, 0, 32'h1, 1'b0, "rd_b2b_busy");
      chk("start_count5", 32'(nstart0), 32'd5);
      pulse_done();
      apb(0, 0, 8'h04, 0, 32'h2, 1'b0, "rd_b2b_done");

      apb(0, 0, 8'h3C, 0, 32'h0, 1'b1, "rd_unmapped");
      apb(0, 1, 8'h3C, 32'hFFFF_FFFF, 0, 1'b1, "wr_unmapped");
`ifdef ROTATE_REGFILE_ID_EN
      apb(0, 0, 8'h14, 0, 32'h524F_5401, 1'b0, "rd_id");
      apb(0, 1, 8'h14, 32'h1234, 0, 1'b1, "wr_id");
`else
      apb(0, 0, 8'h14, 0, 32'h0, 1'b1, "rd_id_absent");
`endif

      apb(1, 1, 8'h08, 32'hA5, 0, 1'b0, "ws_wr_src");
      apb(1, 0, 8'h08, 0, 32'hA5, 1'b0, "ws_rd_src");
      // Drop PSEL during the wait: the write must not land.
      @(posedge clk); #1;
      psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hDEAD;
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk) chk("ws_abort_pready", 32'(pready1), 32'd0);
      @(posedge clk); #1 psel1 = 1'b0; penable = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("ws_abort_src_out", src1, 32'hA5);
      apb(1, 0, 8'h08, 0, 32'hA5, 1'b0, "ws_rd_after_abort");

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/rotate_apb_regfile.md
Name: rotate_apb_regfile

Overview:
Parametrised APB slave register file for the rotate engine. It replaces the fixed start-only control block. It holds the engine configuration (mode, source and destination base addresses, image size) and issues a one-cycle start pulse. It tracks busy/done, sticky error and interrupt status, and supports configurable APB wait states. It sits between the APB bus and the rotate datapath/DMA.

Parameters:
ADDR_W, 8, APB address width (byte address; bits [1:0] ignored)
DATA_W, 32, APB data width; also the width of the SRC/DST address registers
DIM_W, 12, width of each of image width and image height
WAIT_STATES, 0, extra PREADY-low cycles per access (0..7)
ID_VALUE, 32'h524F_5401, ID register value (used only with the optional feature)

Ports:
I_PCLK  in  1  clock
I_PRESET_N  in  1  reset; synchronous, active-high despite the _N suffix (1 = reset)
I_PSEL  in  1  APB select
I_PENABLE  in  1  APB enable
I_PWRITE  in  1  1 = write
I_PADDR  in  ADDR_W  byte address
I_PWDATA  in  DATA_W  write data
O_PRDATA  out  DATA_W  read data; valid when O_PREADY=1; 0 otherwise
O_PREADY  out  1  transfer complete
O_PSLVERR  out  1  error response; valid only with O_PREADY=1
I_DONE  in  1  one-cycle pulse from the engine: job finished
O_START  out  1  one-cycle start pulse to the engine
O_MODE  out  2  0 = 0deg, 1 = 90, 2 = 180, 3 = 270
O_SRC_ADDR  out  DATA_W  source base address
O_DST_ADDR  out  DATA_W  destination base address
O_IMG_W  out  DIM_W  image width in pixels
O_IMG_H  out  DIM_W  image height in pixels
O_IRQ  out  1  level interrupt, registered

Behaviour:
- Reset (I_PRESET_N=1 at a clock edge): all registers and outputs are 0. Reset mid-transfer abandons the transfer and returns to IDLE. O_PREADY stays 0 while reset is held.
- Register map:
  - 0x00 CTRL: [0] START (write-1 action, reads 0); [2:1] MODE; [3] IE.
  - 0x04 STATUS: [0] BUSY (read-only); [1] DONE (write-1-to-clear); [2] ERR (write-1-to-clear).
  - 0x08 SRC_ADDR.
  - 0x0C DST_ADDR.
  - 0x10 SIZE: [DIM_W-1:0] width; [DIM_W+15:16] height.
  - Unwritable bits read 0.
- APB FSM:
  - IDLE -> SETUP when I_PSEL=1 and I_PENABLE=0.
  - SETUP -> ACCESS on the next edge. The wait counter loads WAIT_STATES.
  - ACCESS: O_PREADY=0 while the counter is non-zero; the counter decrements each cycle.
  - At counter 0, O_PREADY=1 for exactly one cycle and the write commits / read data is driven on that cycle.
  - Then -> SETUP if I_PSEL=1, else IDLE.
  - I_PSEL dropping during ACCESS -> IDLE with no commit.
  - With WAIT_STATES=0, every access completes in the standard 2-cycle APB transfer.
- START:
  - A committed write to CTRL with bit0=1 and BUSY=0: O_START=1 the next cycle, BUSY<=1, DONE<=0. MODE/IE update in the same write.
  - With BUSY=1: no pulse, ERR<=1, PSLVERR=1. MODE/IE are also not updated.
- Config lock: writes to 0x08/0x0C/0x10, or to CTRL MODE, while BUSY=1 are ignored with PSLVERR=1. Reads are always allowed.
- I_DONE=1: BUSY<=0, DONE<=1.
  - I_DONE while BUSY=0 is ignored (DONE unchanged).
  - I_DONE on the same cycle as a DONE W1C write: set wins.
- O_IRQ is registered: O_IRQ <= (DONE|ERR) & IE, so it lags by 1 cycle.
- Unmapped address: read returns 0, write is ignored, PSLVERR=1.
- A START write coinciding with I_DONE in the same cycle: done is processed first, then the start is accepted (back-to-back jobs).

Optional Feature:
ROTATE_REGFILE_ID_EN:
- Defined: 0x14 is a read-only ID register returning ID_VALUE. Writes to it give PSLVERR=1.
- Undefined: 0x14 is unmapped (read 0, PSLVERR=1). No ID logic is instantiated.

Test Plan:
- Reset, then read 0x00..0x10 -> all read 0, PSLVERR=0, O_IRQ=0, O_START=0.
- Write SRC=0x1000_0000, DST=0x2000_0000, SIZE=0x00F0_0140, CTRL=0x0B -> one O_START pulse, O_MODE=1, O_IMG_W=320, O_IMG_H=240, STATUS reads 0x1.
- While BUSY: write CTRL=0x01, then write SRC=0x5 -> both PSLVERR=1, no O_START, SRC unchanged, STATUS=0x5, O_IRQ=1 one cycle later (IE=1).
- Pulse I_DONE -> STATUS=0x6. Write STATUS=0x6 -> STATUS=0x0, O_IRQ falls 1 cycle later. DONE W1C coinciding with I_DONE -> DONE stays 1.
- WAIT_STATES=3: each access shows exactly 3 PREADY-low ACCESS cycles. Drop PSEL mid-wait -> no write commit.
- Read 0x14 -> ID_VALUE with ROTATE_REGFILE_ID_EN defined; 0 with PSLVERR=1 without it. Read 0x3C -> 0, PSLVERR=1.
